// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Data beats fetch; a watchdog aborts stuck accesses and flags a sticky error.
module mem_port_arbiter #(
  parameter int data_width     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [data_width-1:0] if_addr,
  output logic [data_width-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [data_width-1:0] d_addr,
  input  logic [data_width-1:0] d_wdata,
  output logic [data_width-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [data_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  stall,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DONE
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [3:0]            be;
    logic [data_width-1:0] addr;
    logic [data_width-1:0] wdata;
  } bus_t;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  bus_t                  bus_q, bus_d;
  logic                  req_q, req_d;
  logic [data_width-1:0] if_rdata_q, if_rdata_d;
  logic [data_width-1:0] d_rdata_q, d_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic                  err_q, err_d;

  logic                  fin;
  logic                  cap;
  logic                  tmo;

  // Access sequencing: arbitration in IDLE, completion or abort in ADDR/RESP.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    fin        = 1'b0;
    cap        = 1'b0;
    tmo        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          owner_d     = OWN_DATA;
          bus_d.we    = d_we;
          bus_d.be    = d_be;
          bus_d.addr  = d_addr;
          bus_d.wdata = d_wdata;
          req_d       = 1'b1;
          cnt_d       = '0;
          state_d     = ADDR;
        end else if (if_req) begin
          owner_d     = OWN_FETCH;
          bus_d.we    = 1'b0;
          bus_d.be    = 4'hF;
          bus_d.addr  = if_addr;
          bus_d.wdata = '0;
          req_d       = 1'b1;
          cnt_d       = '0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_gnt && mem_rvalid) begin
          cap = 1'b1;
          fin = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          tmo = 1'b1;
          fin = 1'b1;
        end else if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_rvalid) begin
          cap = 1'b1;
          fin = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          tmo = 1'b1;
          fin = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d = DONE;
      req_d   = 1'b0;
      if (owner_q == OWN_DATA) begin
        d_rdata_d = cap ? mem_rdata : '0;
      end else begin
        if_rdata_d = cap ? mem_rdata : '0;
      end
    end

    if (tmo) begin
      err_d = 1'b1;
    end

    if_valid_d = fin && (owner_q == OWN_FETCH);
    d_valid_d  = fin && (owner_q == OWN_DATA);
  end

  // State, owner, watchdog and bus registers; reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      cnt_q      <= '0;
      bus_q      <= '0;
      req_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      bus_q      <= bus_d;
      req_q      <= req_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = bus_q.we;
  assign mem_be      = bus_q.be;
  assign mem_addr    = bus_q.addr;
  assign mem_wdata   = bus_q.wdata;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_valid    = if_valid_q;
  assign d_valid     = d_valid_q;
  assign timeout_err = err_q;

  assign stall = (if_req | d_req) & ~(if_valid_q | d_valid_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one external memory port between the instruction-fetch requester and the load/store requester of the RV32I core.
- Used when the core moves to a unified, variable-latency memory. Sits between the datapath (PC/fetch side and load/store side) and the memory bus.
- Drives a stall to freeze the PC and register write-back until the access completes.
- Has a fixed-priority arbiter, a 4-state access FSM, a timeout counter and a sticky error flag.

Parameters:
- data_width, 32, width of address, read data and write data.
- TIMEOUT_CYCLES, 255, number of cycles spent in ADDR+RESP before the access is aborted; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  data_width  fetch address (PC).
- if_rdata  out  data_width  fetched instruction, registered.
- if_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  load/store request; held high until d_valid.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  data_width  data address.
- d_wdata  in  data_width  store data.
- d_rdata  out  data_width  load data, registered.
- d_valid  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  data_width  memory address.
- mem_wdata  out  data_width  memory write data.
- mem_gnt  in  1  memory accepted the address phase.
- mem_rvalid  in  1  response or write acknowledge.
- mem_rdata  in  data_width  memory read data.
- stall  out  1  core must hold PC/regfile.
- timeout_err  out  1  sticky; an access timed out.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs go to 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid, timeout_err.
  - Owner register and timeout counter clear.
  - Reset mid-access abandons the access. A late mem_gnt or mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ADDR, RESP, DONE.
- IDLE:
  - d_req=1: owner=DATA. Latch d_we, d_be, d_addr, d_wdata into the mem_* registers. Go to ADDR.
  - else if_req=1: owner=FETCH. Latch mem_we=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0. Go to ADDR.
  - Fixed priority: data wins over fetch.
  - Neither: stay in IDLE.
  - Requester inputs are sampled only in IDLE. Later changes to them do not affect the access in flight.
- ADDR:
  - mem_req=1, with mem_* outputs held stable until mem_gnt.
  - mem_gnt=1 and mem_rvalid=0: go to RESP; mem_req drops to 0 on the next cycle.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle: capture mem_rdata, go straight to DONE (zero-latency memory).
- RESP:
  - mem_req=0; wait for mem_rvalid.
  - On mem_rvalid: capture mem_rdata into the owner's rdata register (stores capture too; software ignores it). Go to DONE.
- DONE:
  - Owner's valid=1 for exactly one cycle; go to IDLE unconditionally.
  - The requester drops its req on seeing valid, so IDLE samples fresh requests.
  - The non-owner's rdata register is unchanged.
- Timeout:
  - Counter clears on entry to ADDR and increments every cycle in ADDR or RESP.
  - When count reaches TIMEOUT_CYCLES-1 without completion:
    - owner's rdata := 0;
    - timeout_err := 1 (stays set until reset);
    - mem_req := 0;
    - go to DONE (valid still pulses, so the core does not hang).
  - Completion in the same cycle as the timeout takes precedence: data is captured and no error is flagged.
- stall = (if_req | d_req) & ~(if_valid | d_valid), combinational.
- Minimum access latency is 3 cycles from IDLE sample to valid (IDLE → ADDR → DONE). Back-to-back accesses are separated by one IDLE cycle.
- mem_rvalid without a preceding mem_gnt in ADDR is ignored.

Test Plan:
- Reset: hold rst=0 with if_req=1 → all outputs 0 and stall=1. Release rst → mem_req=1, mem_addr=if_addr one cycle later.
- Fetch: if_addr=32'h0000_0010; mem_gnt after 1 cycle; mem_rvalid 2 cycles later with mem_rdata=32'h0050_0093 → if_rdata=32'h0050_0093, if_valid pulses once, d_valid=0.
- Priority: if_req=1 and d_req=1 (d_we=1, d_be=4'b0011, d_addr=32'h100, d_wdata=32'hABCD) in the same cycle → first grant has mem_we=1, mem_be=4'b0011, mem_addr=32'h100. Fetch is served after d_valid and one IDLE cycle.
- Zero latency: mem_gnt=1 and mem_rvalid=1 in the same ADDR cycle with mem_rdata=32'hFFFF_FF80 → d_rdata=32'hFFFF_FF80, d_valid 3 cycles after the request was sampled.
- Timeout: TIMEOUT_CYCLES=8, never assert mem_gnt → after 8 cycles in ADDR, if_valid pulses with if_rdata=0, timeout_err=1 and stays 1 through subsequent good accesses.
- Reset mid-access: assert rst=0 while in RESP, then release; a stray mem_rvalid=1 arrives → no valid pulse, state stays IDLE, all rdata registers remain 0.
